rvfi_regfile_shadow_check: RTL and testbench

- Simulation/formal monitor on the RVFI bus that shadows the whole integer register file (NREGS entries) across all NRET retirement channels.
- Checks every rs1/rs2 read against the shadow, x0 writes, out-of-range addresses, and rvfi_order continuity.
- Instead of asserting inline, it reports the first error with full context plus a saturating error count, so sim benches and formal wrappers share one checker.
- Sits beside the core under test, driven directly by RVFI outputs.

---
 rtl/rvfi_regfile_shadow_check_if.sv | 29 ++
 rtl/rvfi_regfile_shadow_check.sv | 230 +++++++++++++++++++++++
 tb/tb_rvfi_regfile_shadow_check.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_regfile_shadow_check_if.sv
// RVFI retirement bus as seen by the register-file shadow checker.
// The core (or bench) drives it through master; the checker samples it through slave.
`timescale 1ns/1ps
interface rvfi_regfile_shadow_check_if #(
    parameter int NRET = 1,
    parameter int XLEN = 32
);
    logic [NRET-1:0]      rvfi_valid;
    logic [NRET*64-1:0]   rvfi_order;
    logic [NRET-1:0]      rvfi_trap;
    logic [NRET*5-1:0]    rvfi_rs1_addr;
    logic [NRET*5-1:0]    rvfi_rs2_addr;
    logic [NRET*XLEN-1:0] rvfi_rs1_rdata;
    logic [NRET*XLEN-1:0] rvfi_rs2_rdata;
    logic [NRET*5-1:0]    rvfi_rd_addr;
    logic [NRET*XLEN-1:0] rvfi_rd_wdata;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_trap,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_addr, rvfi_rd_wdata
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_trap,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_addr, rvfi_rd_wdata
    );
endinterface

// File: rtl/rvfi_regfile_shadow_check.sv
// Shadows the integer register file from RVFI retirements and reports the first
// inconsistency (operand mismatch, x0 write, order gap, bad index) plus an error count.
`timescale 1ns/1ps
module rvfi_regfile_shadow_check #(
    parameter int NRET      = 1,
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ZERO_INIT = 0,
    parameter int CNT_W     = 16,
    localparam int CH_W     = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 check_en,
    rvfi_regfile_shadow_check_if.slave rvfi,
    output logic                 err,
    output logic [CNT_W-1:0]     err_count,
    output logic [2:0]           err_code,
    output logic [CH_W-1:0]      err_channel,
    output logic [63:0]          err_order,
    output logic [4:0]           err_reg,
    output logic [XLEN-1:0]      err_expected,
    output logic [XLEN-1:0]      err_actual
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] RS1_MISMATCH = 3'd1;
    localparam logic [2:0] RS2_MISMATCH = 3'd2;
    localparam logic [2:0] X0_WRITE     = 3'd3;
    localparam logic [2:0] ORDER_GAP    = 3'd4;
    localparam logic [2:0] ADDR_RANGE   = 3'd5;

    // Check slots per channel, listed in first-error priority order.
    localparam int NSLOT     = 7;
    localparam int S_ORDER   = 0;
    localparam int S_RS1_RNG = 1;
    localparam int S_RS2_RNG = 2;
    localparam int S_RD_RNG  = 3;
    localparam int S_RS1     = 4;
    localparam int S_RS2     = 5;
    localparam int S_X0      = 6;

    logic [XLEN-1:0]  shadow [NREGS];
    logic [NREGS-1:0] written;
    logic             order_seen;
    logic [63:0]      next_order;

    logic [XLEN-1:0]  sh_n [NREGS];
    logic [NREGS-1:0] wr_n;
    logic             seen_n;
    logic [63:0]      nord_n;
    logic [CNT_W-1:0] cnt_n;
    logic             any_ev;
    logic             found;
    logic [2:0]       c_code;
    logic [CH_W-1:0]  c_ch;
    logic [63:0]      c_order;
    logic [4:0]       c_reg;
    logic [XLEN-1:0]  c_exp;
    logic [XLEN-1:0]  c_act;

    logic [63:0]      ord;
    logic [4:0]       rs1a, rs2a, rda;
    logic [XLEN-1:0]  rs1d, rs2d, rdd;
    logic [XLEN-1:0]  exp1, exp2;
    logic [NSLOT-1:0] hit;
    logic [4:0]       s_reg [NSLOT];
    logic [XLEN-1:0]  s_exp [NSLOT];
    logic [XLEN-1:0]  s_act [NSLOT];

    function automatic logic [2:0] slot_code(input int s);
        case (s)
            S_ORDER:                      return ORDER_GAP;
            S_RS1_RNG, S_RS2_RNG, S_RD_RNG: return ADDR_RANGE;
            S_RS1:                        return RS1_MISMATCH;
            S_RS2:                        return RS2_MISMATCH;
            default:                      return X0_WRITE;
        endcase
    endfunction

    // Channels are walked in ascending order against a working copy of the
    // shadow, so a later channel observes writes retired by earlier ones.
    always_comb begin
        sh_n    = shadow;
        wr_n    = written;
        seen_n  = order_seen;
        nord_n  = next_order;
        cnt_n   = err_count;
        any_ev  = 1'b0;
        found   = 1'b0;
        c_code  = '0;
        c_ch    = '0;
        c_order = '0;
        c_reg   = '0;
        c_exp   = '0;
        c_act   = '0;
        ord     = '0;
        rs1a    = '0;
        rs2a    = '0;
        rda     = '0;
        rs1d    = '0;
        rs2d    = '0;
        rdd     = '0;
        exp1    = '0;
        exp2    = '0;
        hit     = '0;
        s_reg   = '{default: '0};
        s_exp   = '{default: '0};
        s_act   = '{default: '0};

        if (check_en) begin
            for (int k = 0; k < NRET; k++) begin
                hit   = '0;
                s_reg = '{default: '0};
                s_exp = '{default: '0};
                s_act = '{default: '0};
                ord   = rvfi.rvfi_order[k*64 +: 64];
                rs1a  = rvfi.rvfi_rs1_addr[k*5 +: 5];
                rs2a  = rvfi.rvfi_rs2_addr[k*5 +: 5];
                rda   = rvfi.rvfi_rd_addr[k*5 +: 5];
                rs1d  = rvfi.rvfi_rs1_rdata[k*XLEN +: XLEN];
                rs2d  = rvfi.rvfi_rs2_rdata[k*XLEN +: XLEN];
                rdd   = rvfi.rvfi_rd_wdata[k*XLEN +: XLEN];

                if (rvfi.rvfi_valid[k]) begin
                    // Resync after a gap so each discontinuity costs one event.
                    if (seen_n && ord != nord_n) begin
                        hit[S_ORDER]   = 1'b1;
                        s_exp[S_ORDER] = XLEN'(nord_n);
                        s_act[S_ORDER] = XLEN'(ord);
                    end
                    nord_n = ord + 64'd1;
                    seen_n = 1'b1;

                    if (!rvfi.rvfi_trap[k]) begin
                        exp1 = (rs1a == 5'd0) ? '0 : sh_n[rs1a[RW-1:0]];
                        exp2 = (rs2a == 5'd0) ? '0 : sh_n[rs2a[RW-1:0]];

                        if (int'(rs1a) >= NREGS) begin
                            hit[S_RS1_RNG]   = 1'b1;
                            s_reg[S_RS1_RNG] = rs1a;
                        end else if ((rs1a == 5'd0 || wr_n[rs1a[RW-1:0]]) && rs1d != exp1) begin
                            hit[S_RS1]   = 1'b1;
                            s_reg[S_RS1] = rs1a;
                            s_exp[S_RS1] = exp1;
                            s_act[S_RS1] = rs1d;
                        end

                        if (int'(rs2a) >= NREGS) begin
                            hit[S_RS2_RNG]   = 1'b1;
                            s_reg[S_RS2_RNG] = rs2a;
                        end else if ((rs2a == 5'd0 || wr_n[rs2a[RW-1:0]]) && rs2d != exp2) begin
                            hit[S_RS2]   = 1'b1;
                            s_reg[S_RS2] = rs2a;
                            s_exp[S_RS2] = exp2;
                            s_act[S_RS2] = rs2d;
                        end

                        if (int'(rda) >= NREGS) begin
                            hit[S_RD_RNG]   = 1'b1;
                            s_reg[S_RD_RNG] = rda;
                        end else if (rda == 5'd0) begin
                            if (rdd != '0) begin
                                hit[S_X0]   = 1'b1;
                                s_act[S_X0] = rdd;
                            end
                        end else begin
                            sh_n[rda[RW-1:0]] = rdd;
                            wr_n[rda[RW-1:0]] = 1'b1;
                        end
                    end

                    for (int s = 0; s < NSLOT; s++) begin
                        if (hit[s]) begin
                            any_ev = 1'b1;
                            if (cnt_n != {CNT_W{1'b1}})
                                cnt_n = cnt_n + 1'b1;
                            if (!found) begin
                                found   = 1'b1;
                                c_code  = slot_code(s);
                                c_ch    = CH_W'(k);
                                c_order = ord;
                                c_reg   = s_reg[s];
                                c_exp   = s_exp[s];
                                c_act   = s_act[s];
                            end
                        end
                    end
                end
            end
        end
    end

    // First-error fields latch only while err is clear and then hold until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++)
                shadow[i] <= '0;
            written      <= (ZERO_INIT != 0) ? {NREGS{1'b1}} : '0;
            order_seen   <= 1'b0;
            next_order   <= '0;
            err          <= 1'b0;
            err_count    <= '0;
            err_code     <= '0;
            err_channel  <= '0;
            err_order    <= '0;
            err_reg      <= '0;
            err_expected <= '0;
            err_actual   <= '0;
        end else if (check_en) begin
            shadow     <= sh_n;
            written    <= wr_n;
            order_seen <= seen_n;
            next_order <= nord_n;
            err_count  <= cnt_n;
            if (any_ev)
                err <= 1'b1;
            if (!err && found) begin
                err_code     <= c_code;
                err_channel  <= c_ch;
                err_order    <= c_order;
                err_reg      <= c_reg;
                err_expected <= c_exp;
                err_actual   <= c_act;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_regfile_shadow_check.sv
// Scoreboard bench: directed retirements push hand-computed checker states into a
// queue, and a negedge monitor compares them against the two checker instances.
`timescale 1ns/1ps
module tb_rvfi_regfile_shadow_check;

    logic clk = 1'b0;
    logic resetn;
    logic en1, en2;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rvfi_regfile_shadow_check_if #(.NRET(1), .XLEN(32)) bus1 ();
    rvfi_regfile_shadow_check_if #(.NRET(2), .XLEN(32)) bus2 ();

    logic        o1_err, o2_err;
    logic [15:0] o1_cnt, o2_cnt;
    logic [2:0]  o1_code, o2_code;
    logic        o1_ch, o2_ch;
    logic [63:0] o1_order, o2_order;
    logic [4:0]  o1_reg, o2_reg;
    logic [31:0] o1_exp, o2_exp, o1_act, o2_act;

    // dut1: single channel, registers unchecked until written.
    rvfi_regfile_shadow_check #(.NRET(1), .XLEN(32), .NREGS(32), .ZERO_INIT(0), .CNT_W(16)) dut1 (
        .clk(clk), .resetn(resetn), .check_en(en1), .rvfi(bus1),
        .err(o1_err), .err_count(o1_cnt), .err_code(o1_code), .err_channel(o1_ch),
        .err_order(o1_order), .err_reg(o1_reg), .err_expected(o1_exp), .err_actual(o1_act)
    );

    // dut2: two channels, RV32E-sized file, all registers start as written zero.
    rvfi_regfile_shadow_check #(.NRET(2), .XLEN(32), .NREGS(16), .ZERO_INIT(1), .CNT_W(16)) dut2 (
        .clk(clk), .resetn(resetn), .check_en(en2), .rvfi(bus2),
        .err(o2_err), .err_count(o2_cnt), .err_code(o2_code), .err_channel(o2_ch),
        .err_order(o2_order), .err_reg(o2_reg), .err_expected(o2_exp), .err_actual(o2_act)
    );

    typedef struct {
        logic [63:0] order;
        logic        trap;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, wd;
    } retire_t;

    typedef struct {
        int          sel;
        int          tag;
        logic        chk;
        logic        err;
        logic [15:0] cnt;
        logic [2:0]  code;
        logic        ch;
        logic [63:0] order;
        logic [4:0]  rg;
        logic [31:0] ex;
        logic [31:0] ac;
        int          due;
    } exp_t;

    exp_t q[$];

    function automatic retire_t rt(input logic [63:0] order, input logic [4:0] rs1, input logic [31:0] d1,
                                   input logic [4:0] rs2, input logic [31:0] d2,
                                   input logic [4:0] rd, input logic [31:0] wd, input logic trap);
        retire_t r;
        r.order = order; r.rs1 = rs1; r.d1 = d1; r.rs2 = rs2; r.d2 = d2;
        r.rd = rd; r.wd = wd; r.trap = trap;
        return r;
    endfunction

    function automatic exp_t xp(input int sel, input int tag, input logic [15:0] cnt, input logic [2:0] code,
                                input logic ch, input logic [63:0] order, input logic [4:0] rg,
                                input logic [31:0] ex, input logic [31:0] ac);
        exp_t e;
        e.sel = sel; e.tag = tag; e.chk = 1'b1; e.err = (cnt != 16'd0); e.cnt = cnt;
        e.code = code; e.ch = ch; e.order = order; e.rg = rg; e.ex = ex; e.ac = ac; e.due = 0;
        return e;
    endfunction

    function automatic exp_t clean(input int sel, input int tag);
        return xp(sel, tag, 16'd0, 3'd0, 1'b0, 64'd0, 5'd0, 32'd0, 32'd0);
    endfunction

    task automatic checkOutput(input exp_t e);
        logic        a_err;
        logic [15:0] a_cnt;
        logic [2:0]  a_code;
        logic        a_ch;
        logic [63:0] a_order;
        logic [4:0]  a_reg;
        logic [31:0] a_exp, a_act;
        if (e.sel == 1) begin
            a_err = o1_err; a_cnt = o1_cnt; a_code = o1_code; a_ch = o1_ch;
            a_order = o1_order; a_reg = o1_reg; a_exp = o1_exp; a_act = o1_act;
        end else begin
            a_err = o2_err; a_cnt = o2_cnt; a_code = o2_code; a_ch = o2_ch;
            a_order = o2_order; a_reg = o2_reg; a_exp = o2_exp; a_act = o2_act;
        end
        checks++;
        if (a_err !== e.err || a_cnt !== e.cnt || a_code !== e.code || a_ch !== e.ch ||
            a_order !== e.order || a_reg !== e.rg || a_exp !== e.ex || a_act !== e.ac) begin
            errors++;
            $display("[TB] FAIL v%0d dut%0d: got err=%0b cnt=%h code=%0d ch=%0d order=%0d reg=%0d exp=%h act=%h, want err=%0b cnt=%h code=%0d ch=%0d order=%0d reg=%0d exp=%h act=%h",
                     e.tag, e.sel, a_err, a_cnt, a_code, a_ch, a_order, a_reg, a_exp, a_act,
                     e.err, e.cnt, e.code, e.ch, e.order, e.rg, e.ex, e.ac);
        end
    endtask

    task automatic clearBus();
        bus1.rvfi_valid = '0; bus1.rvfi_order = '0; bus1.rvfi_trap = '0;
        bus1.rvfi_rs1_addr = '0; bus1.rvfi_rs2_addr = '0; bus1.rvfi_rd_addr = '0;
        bus1.rvfi_rs1_rdata = '0; bus1.rvfi_rs2_rdata = '0; bus1.rvfi_rd_wdata = '0;
        bus2.rvfi_valid = '0; bus2.rvfi_order = '0; bus2.rvfi_trap = '0;
        bus2.rvfi_rs1_addr = '0; bus2.rvfi_rs2_addr = '0; bus2.rvfi_rd_addr = '0;
        bus2.rvfi_rs1_rdata = '0; bus2.rvfi_rs2_rdata = '0; bus2.rvfi_rd_wdata = '0;
    endtask

    task automatic applyStimulus(input int sel, input logic en, input logic [1:0] vld,
                                 input retire_t r0, input retire_t r1, input exp_t e);
        @(negedge clk);
        bus1.rvfi_valid = '0;
        bus2.rvfi_valid = '0;
        if (sel == 1) begin
            en1 = en;
            bus1.rvfi_valid     = vld[0];
            bus1.rvfi_order     = r0.order;
            bus1.rvfi_trap      = r0.trap;
            bus1.rvfi_rs1_addr  = r0.rs1;
            bus1.rvfi_rs2_addr  = r0.rs2;
            bus1.rvfi_rd_addr   = r0.rd;
            bus1.rvfi_rs1_rdata = r0.d1;
            bus1.rvfi_rs2_rdata = r0.d2;
            bus1.rvfi_rd_wdata  = r0.wd;
        end else begin
            en2 = en;
            bus2.rvfi_valid     = vld;
            bus2.rvfi_order     = {r1.order, r0.order};
            bus2.rvfi_trap      = {r1.trap, r0.trap};
            bus2.rvfi_rs1_addr  = {r1.rs1, r0.rs1};
            bus2.rvfi_rs2_addr  = {r1.rs2, r0.rs2};
            bus2.rvfi_rd_addr   = {r1.rd, r0.rd};
            bus2.rvfi_rs1_rdata = {r1.d1, r0.d1};
            bus2.rvfi_rs2_rdata = {r1.d2, r0.d2};
            bus2.rvfi_rd_wdata  = {r1.wd, r0.wd};
        end
        e.due = cyc + 1;
        if (e.chk)
            q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus1.rvfi_valid = '0;
        bus2.rvfi_valid = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", q.size());
            q.delete();
        end
    endtask

    // Reset is asserted away from any clock edge; outputs must clear at once.
    task automatic doReset(input int tag);
        idle();
        drain();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput(clean(1, tag));
        checkOutput(clean(2, tag));
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                m = q.pop_front();
                checkOutput(m);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        retire_t nop;
        exp_t    e;
        nop    = rt(64'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        resetn = 1'b0;
        en1    = 1'b1;
        en2    = 1'b1;
        clearBus();
        #3;
        checkOutput(clean(1, 1));
        checkOutput(clean(2, 1));
        @(negedge clk);
        resetn = 1'b1;

        // Write then read x5; a wrong rs2 value is the first error.
        applyStimulus(1, 1, 2'b01, rt(0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0), nop, clean(1, 10));
        applyStimulus(1, 1, 2'b01, rt(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0), nop, clean(1, 11));
        applyStimulus(1, 1, 2'b01, rt(2, 0, 0, 5, 0, 0, 0, 0), nop,
                      xp(1, 12, 16'd1, 3'd2, 1'b0, 64'd2, 5'd5, 32'hDEADBEEF, 32'd0));
        applyStimulus(1, 1, 2'b01, rt(3, 7, 32'h1234, 0, 0, 0, 0, 0), nop,
                      xp(1, 13, 16'd1, 3'd2, 1'b0, 64'd2, 5'd5, 32'hDEADBEEF, 32'd0));
        doReset(2);

        // Zero-initialised file: an unwritten x7 already reads as 0.
        applyStimulus(2, 1, 2'b01, rt(0, 7, 32'h1234, 0, 0, 0, 0, 0), nop,
                      xp(2, 20, 16'd1, 3'd1, 1'b0, 64'd0, 5'd7, 32'd0, 32'h1234));
        doReset(3);

        // Same-cycle forwarding from channel 0 to channel 1.
        applyStimulus(2, 1, 2'b11, rt(4, 0, 0, 0, 0, 3, 32'h10, 0), rt(5, 3, 32'h10, 0, 0, 0, 0, 0),
                      clean(2, 21));
        applyStimulus(2, 1, 2'b11, rt(6, 0, 0, 0, 0, 3, 32'h10, 0), rt(7, 3, 32'h11, 0, 0, 0, 0, 0),
                      xp(2, 22, 16'd1, 3'd1, 1'b1, 64'd7, 5'd3, 32'h10, 32'h11));
        doReset(4);

        // Two events in one cycle: channel 0 rs2 mismatch wins over channel 1 gap.
        applyStimulus(2, 1, 2'b11, rt(0, 0, 0, 4, 32'h9, 0, 0, 0), rt(5, 0, 0, 0, 0, 0, 0, 0),
                      xp(2, 23, 16'd2, 3'd2, 1'b0, 64'd0, 5'd4, 32'd0, 32'h9));
        doReset(5);

        // Out-of-range rs1 outranks an rs2 mismatch in the same channel.
        applyStimulus(2, 1, 2'b01, rt(0, 20, 0, 4, 32'h9, 0, 0, 0), nop,
                      xp(2, 24, 16'd2, 3'd5, 1'b0, 64'd0, 5'd20, 32'd0, 32'd0));
        doReset(6);

        // Order 0,1,3,4: one gap, then disabled bus, then resume and another gap.
        applyStimulus(1, 1, 2'b01, rt(0, 0, 0, 0, 0, 0, 0, 0), nop, clean(1, 30));
        applyStimulus(1, 1, 2'b01, rt(1, 0, 0, 0, 0, 0, 0, 0), nop, clean(1, 31));
        applyStimulus(1, 1, 2'b01, rt(3, 0, 0, 0, 0, 0, 0, 0), nop,
                      xp(1, 32, 16'd1, 3'd4, 1'b0, 64'd3, 5'd0, 32'd2, 32'd3));
        applyStimulus(1, 1, 2'b01, rt(4, 0, 0, 0, 0, 0, 0, 0), nop,
                      xp(1, 33, 16'd1, 3'd4, 1'b0, 64'd3, 5'd0, 32'd2, 32'd3));
        applyStimulus(1, 0, 2'b01, rt(9, 0, 0, 0, 0, 0, 32'h1, 0), nop,
                      xp(1, 34, 16'd1, 3'd4, 1'b0, 64'd3, 5'd0, 32'd2, 32'd3));
        applyStimulus(1, 1, 2'b01, rt(5, 0, 0, 0, 0, 0, 0, 0), nop,
                      xp(1, 35, 16'd1, 3'd4, 1'b0, 64'd3, 5'd0, 32'd2, 32'd3));
        applyStimulus(1, 1, 2'b01, rt(7, 0, 0, 0, 0, 0, 0, 0), nop,
                      xp(1, 36, 16'd2, 3'd4, 1'b0, 64'd3, 5'd0, 32'd2, 32'd3));
        doReset(7);

        // A trapped retire neither writes x9 nor checks its operands.
        applyStimulus(1, 1, 2'b01, rt(0, 0, 0, 0, 0, 9, 32'h0, 0), nop, clean(1, 40));
        applyStimulus(1, 1, 2'b01, rt(1, 9, 32'h77, 0, 0, 9, 32'h55, 1), nop, clean(1, 41));
        applyStimulus(1, 1, 2'b01, rt(2, 9, 32'h0, 0, 0, 0, 0, 0), nop, clean(1, 42));
        doReset(8);
        applyStimulus(1, 1, 2'b01, rt(100, 0, 0, 0, 0, 0, 0, 0), nop, clean(1, 43));

        // x0 write, then enough x0 read mismatches to saturate the counter.
        applyStimulus(1, 1, 2'b01, rt(101, 0, 0, 0, 0, 0, 32'h1, 0), nop,
                      xp(1, 50, 16'd1, 3'd3, 1'b0, 64'd101, 5'd0, 32'd0, 32'h1));
        for (int i = 0; i < 70000; i++) begin
            e = xp(1, 51, 16'hFFFF, 3'd3, 1'b0, 64'd101, 5'd0, 32'd0, 32'h1);
            e.chk = (i == 69999);
            applyStimulus(1, 1, 2'b01, rt(64'd102 + 64'(i), 0, 32'h1, 0, 0, 0, 0, 0), nop, e);
        end
        applyStimulus(1, 1, 2'b01, rt(70102, 0, 32'h1, 0, 0, 0, 0, 0), nop,
                      xp(1, 52, 16'hFFFF, 3'd3, 1'b0, 64'd101, 5'd0, 32'd0, 32'h1));

        idle();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
